martes_seq: RTL

Burst sequencer that drives the `martes` storage/datapath block through a write pass followed by a read pass. It steps the `dir` address in word strides, holds each address for a fixed dwell, and captures every read word. It also counts `zeroFlag` hits and reports completion with a start/busy/done handshake. It sits between the test/control logic and `martes`, replacing hand-sequenced `dir`/`en` stimulus.

---
 rtl/martes_seq.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/martes_seq.sv
// martes_seq: write-then-read burst sequencer driving martes dir/en with per-word dwell and read capture.
// Optional abort input is enabled by defining MARTES_SEQ_ABORT_EN.
module martes_seq #(
  parameter int ADDR_W = 7,
  parameter int DATA_W = 32,
  parameter int STEP   = 4,
  parameter int DWELL  = 50
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base,
  input  logic [5:0]        count,
  input  logic              wr_pass,
  input  logic [DATA_W-1:0] dataOut,
  input  logic              zeroFlag,
`ifdef MARTES_SEQ_ABORT_EN
  input  logic              abort,
`endif
  output logic [ADDR_W-1:0] dir,
  output logic              en,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic              rd_valid,
  output logic [DATA_W-1:0] rd_data,
  output logic [5:0]        rd_index,
  output logic [5:0]        zero_cnt
);
  typedef enum logic [2:0] {IDLE, WRITE, GAP, READ, DONE} state_t;
  localparam int AW = ADDR_W + 8;
  localparam logic [AW-1:0] MAX_ADDR = AW'((1 << ADDR_W) - 1);
  localparam logic [7:0] DW_LAST = 8'(DWELL - 1);
  state_t r_state, w_state;
  logic [ADDR_W-1:0] r_base, w_base, r_dir, w_dir;
  logic [5:0] r_cnt, w_cnt, r_i, w_i, r_rd_index, w_rd_index, r_zero_cnt, w_zero_cnt;
  logic [7:0] r_dw, w_dw;
  logic r_en, w_en, r_busy, w_busy, r_done, w_done, r_err, w_err, r_rd_valid, w_rd_valid;
  logic [DATA_W-1:0] r_rd_data, w_rd_data;
  logic [AW-1:0] w_end;
  logic w_bad, w_last_dw, w_last_i;
  // Highest address the requested burst would touch, computed wide so it cannot wrap.
  assign w_end = AW'(base) + AW'(STEP) * AW'(count - 6'd1);
  assign w_bad = ((AW'(base) % AW'(STEP)) != '0) || (count > 6'd32) || (count != 6'd0 && w_end > MAX_ADDR);
  assign w_last_dw = r_dw == DW_LAST;
  assign w_last_i = r_i == r_cnt - 6'd1;
  always_comb begin
    w_state = r_state;
    w_base = r_base;
    w_cnt = r_cnt;
    w_i = r_i;
    w_dw = r_dw;
    w_dir = r_dir;
    w_en = r_en;
    w_busy = r_busy;
    w_done = 1'b0;
    w_err = 1'b0;
    w_rd_valid = 1'b0;
    w_rd_data = r_rd_data;
    w_rd_index = r_rd_index;
    w_zero_cnt = r_zero_cnt;
    case (r_state)
      IDLE: if (start) begin
        if (w_bad) w_err = 1'b1;
        else begin
          w_base = base;
          w_cnt = count;
          w_i = '0;
          w_dw = '0;
          w_zero_cnt = '0;
          w_dir = count == 6'd0 ? r_dir : base;
          w_state = count == 6'd0 ? DONE : wr_pass ? WRITE : READ;
          w_en = count != 6'd0 && wr_pass;
          w_busy = count != 6'd0;
          w_done = count == 6'd0;
        end
      end
      WRITE: begin
        w_dw = w_last_dw ? '0 : r_dw + 8'd1;
        if (w_last_dw && w_last_i) begin
          w_state = GAP;
          w_en = 1'b0;
          w_dir = r_base;
          w_i = '0;
        end else if (w_last_dw) begin
          w_i = r_i + 6'd1;
          w_dir = r_dir + ADDR_W'(STEP);
        end
      end
      GAP: w_state = READ;
      READ: begin
        w_dw = w_last_dw ? '0 : r_dw + 8'd1;
        if (w_last_dw) begin
          w_rd_data = dataOut;
          w_rd_index = r_i;
          w_rd_valid = 1'b1;
          w_zero_cnt = r_zero_cnt + 6'(zeroFlag && r_zero_cnt < 6'd32);
          w_state = w_last_i ? DONE : READ;
          w_busy = !w_last_i;
          w_done = w_last_i;
          w_i = w_last_i ? r_i : r_i + 6'd1;
          w_dir = w_last_i ? r_dir : r_dir + ADDR_W'(STEP);
        end
      end
      DONE: w_state = IDLE;
      default: w_state = IDLE;
    endcase
`ifdef MARTES_SEQ_ABORT_EN
    if (abort && (r_state == WRITE || r_state == GAP || r_state == READ)) begin
      w_state = DONE;
      w_en = 1'b0;
      w_busy = 1'b0;
      w_done = 1'b1;
      w_dir = r_dir;
      w_i = r_i;
      w_dw = '0;
    end
`endif
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_base <= '0;
      r_cnt <= '0;
      r_i <= '0;
      r_dw <= '0;
      r_dir <= '0;
      r_en <= 1'b0;
      r_busy <= 1'b0;
      r_done <= 1'b0;
      r_err <= 1'b0;
      r_rd_valid <= 1'b0;
      r_rd_data <= '0;
      r_rd_index <= '0;
      r_zero_cnt <= '0;
    end else begin
      r_state <= w_state;
      r_base <= w_base;
      r_cnt <= w_cnt;
      r_i <= w_i;
      r_dw <= w_dw;
      r_dir <= w_dir;
      r_en <= w_en;
      r_busy <= w_busy;
      r_done <= w_done;
      r_err <= w_err;
      r_rd_valid <= w_rd_valid;
      r_rd_data <= w_rd_data;
      r_rd_index <= w_rd_index;
      r_zero_cnt <= w_zero_cnt;
    end
  end
  assign dir = r_dir;
  assign en = r_en;
  assign busy = r_busy;
  assign done = r_done;
  assign err = r_err;
  assign rd_valid = r_rd_valid;
  assign rd_data = r_rd_data;
  assign rd_index = r_rd_index;
  assign zero_cnt = r_zero_cnt;
endmodule
